// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the valid/ready pipeline stage registers.
//   - Stage occupancy/state encoding (EMPTY / ONE / TWO).
//   - Field widths and bit offsets of the default five-field payload
//     (instr, pc, ext, rd1, rd2), so every stage packs and unpacks its
//     fields at the same positions.
//   - Helpers to pack/unpack the default payload and to compute parity of
//     a payload for optional integrity checks.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Stage state is encoded directly as the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // Field widths of the default payload.
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int EXT_W   = 32;
  localparam int RD1_W   = 32;
  localparam int RD2_W   = 32;

  localparam int STAGE_DATA_W = INSTR_W + PC_W + EXT_W + RD1_W + RD2_W;

  // LSB offsets: instr occupies the top word, rd2 the bottom word.
  localparam int RD2_LSB   = 0;
  localparam int RD1_LSB   = RD2_LSB + RD2_W;
  localparam int EXT_LSB   = RD1_LSB + RD1_W;
  localparam int PC_LSB    = EXT_LSB + EXT_W;
  localparam int INSTR_LSB = PC_LSB + PC_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [EXT_W-1:0]   ext;
    logic [RD1_W-1:0]   rd1;
    logic [RD2_W-1:0]   rd2;
  } stage_fields_t;

  // Concatenate the five fields in the canonical order.
  function automatic logic [STAGE_DATA_W-1:0] pack_fields(input stage_fields_t f);
    return {f.instr, f.pc, f.ext, f.rd1, f.rd2};
  endfunction

  // Split a packed payload back into its fields.
  function automatic stage_fields_t unpack_fields(input logic [STAGE_DATA_W-1:0] d);
    stage_fields_t f;
    f.instr = d[INSTR_LSB +: INSTR_W];
    f.pc    = d[PC_LSB    +: PC_W];
    f.ext   = d[EXT_LSB   +: EXT_W];
    f.rd1   = d[RD1_LSB   +: RD1_W];
    f.rd2   = d[RD2_LSB   +: RD2_W];
    return f;
  endfunction

  // Even parity over a default-width payload.
  function automatic logic payload_parity(input logic [STAGE_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One payload + valid register of a pipeline stage.
// Priority: reset > clear > load > hold. Clearing or resetting the slot
// returns the payload to BUBBLE_VAL so an empty slot always shows a bubble.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   clear       : drop the held entry (payload <= BUBBLE_VAL, valid <= 0)
//   load        : capture load_data as a valid entry
//   load_data   : payload to capture
//   data, valid : registered slot contents
// -----------------------------------------------------------------------------
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = STAGE_DATA_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  logic [DATA_W-1:0] data_r;
  logic              valid_r;

  // Slot payload/valid register with clear-to-bubble and load.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r  <= BUBBLE_VAL;
      valid_r <= 1'b0;
    end else if (clear) begin
      data_r  <= BUBBLE_VAL;
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= load_data;
      valid_r <= 1'b1;
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
    end
  end

  assign data  = data_r;
  assign valid = valid_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Parametrised pipeline stage register with valid/ready handshake and a
// two-entry skid buffer. Slot M is the head shown downstream, slot S
// catches the one extra entry that can arrive while M is stalled, so
// in_ready depends only on registered state.
// Flush empties both slots; a same-cycle accept is consumed and dropped.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   flush               : discard all held and incoming entries this cycle
//   in_valid/in_ready   : upstream handshake (in_ready = skid slot empty)
//   in_data             : upstream payload
//   out_valid/out_ready : downstream handshake
//   out_data            : head payload, BUBBLE_VAL when out_valid = 0
//   occupancy           : number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = STAGE_DATA_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  stage_state_e      state_r;
  stage_state_e      state_next_s;

  logic              m_load_s;
  logic              m_clear_s;
  logic [DATA_W-1:0] m_load_data_s;
  logic              s_load_s;
  logic              s_clear_s;

  logic [DATA_W-1:0] m_data_s;
  logic              m_valid_s;
  logic [DATA_W-1:0] s_data_s;
  logic              s_valid_s;

  logic              accept_s;
  logic              drain_s;

  assign accept_s = in_valid & in_ready;
  assign drain_s  = out_valid & out_ready;

  // State register; tracks occupancy in lockstep with the slot valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and slot control.
  always_comb begin
    state_next_s  = state_r;
    m_load_s      = 1'b0;
    m_clear_s     = 1'b0;
    m_load_data_s = in_data;
    s_load_s      = 1'b0;
    s_clear_s     = 1'b0;

    if (flush) begin
      // Any accept this cycle is swallowed; the drain already happened.
      m_clear_s    = 1'b1;
      s_clear_s    = 1'b1;
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            m_load_s     = 1'b1;
            state_next_s = ST_ONE;
          end else begin
            state_next_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            m_load_s     = 1'b1;
            state_next_s = ST_ONE;
          end else if (accept_s) begin
            s_load_s     = 1'b1;
            state_next_s = ST_TWO;
          end else if (drain_s) begin
            m_clear_s    = 1'b1;
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_ONE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a drain can move the state.
          if (drain_s) begin
            m_load_s      = 1'b1;
            m_load_data_s = s_data_s;
            s_clear_s     = 1'b1;
            state_next_s  = ST_ONE;
          end else begin
            state_next_s = ST_TWO;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          m_clear_s    = 1'b1;
          s_clear_s    = 1'b1;
          state_next_s = ST_EMPTY;
        end
      endcase
    end
  end

  pipe_slot #(
    .DATA_W    (DATA_W),
    .BUBBLE_VAL(BUBBLE_VAL)
  ) u_slot_m (
    .clk      (clk),
    .reset    (reset),
    .clear    (m_clear_s),
    .load     (m_load_s),
    .load_data(m_load_data_s),
    .data     (m_data_s),
    .valid    (m_valid_s)
  );

  pipe_slot #(
    .DATA_W    (DATA_W),
    .BUBBLE_VAL(BUBBLE_VAL)
  ) u_slot_s (
    .clk      (clk),
    .reset    (reset),
    .clear    (s_clear_s),
    .load     (s_load_s),
    .load_data(in_data),
    .data     (s_data_s),
    .valid    (s_valid_s)
  );

  assign in_ready  = ~s_valid_s;
  assign out_valid = m_valid_s;
  assign out_data  = m_data_s;
  assign occupancy = state_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
// Self-checking bench: a queue-based FIFO model of the stage (capacity 2)
// is compared against the DUT after every clock edge, plus directed
// sequences with hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int W = 160;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int checks;
  int errors;

  logic [W-1:0] q[$];

  pipe_stage_skid dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output with what the FIFO model says it must be.
  task automatic compare_model();
    logic [W-1:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : '0;
    chk("out_valid", W'(out_valid), W'(q.size() > 0));
    chk("out_data",  out_data, exp_data);
    chk("in_ready",  W'(in_ready), W'(q.size() < 2));
    chk("occupancy", W'(occupancy), W'(q.size()));
  endtask

  // Apply one clock edge: advance the model with the inputs present at the
  // edge, then check the DUT shortly after the edge.
  task automatic cycle();
    logic         hold;
    logic [W-1:0] prev;
    logic         acc;
    logic         drn;
    hold = (out_valid === 1'b1) && !out_ready && !flush && !reset;
    prev = out_data;
    if (reset) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() > 0);
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
    @(posedge clk);
    #1;
    compare_model();
    if (hold) chk("stable", out_data, prev);
  endtask

  task automatic push(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(32'hABCD);
    out_ready = 1'b0;

    // Reset held for two cycles with upstream offering data.
    cycle();
    cycle();
    chk("rst_out_valid", W'(out_valid), W'(1'b0));
    chk("rst_out_data",  out_data, W'(0));
    chk("rst_in_ready",  W'(in_ready), W'(1'b1));
    chk("rst_occupancy", W'(occupancy), W'(0));
    reset    = 1'b0;
    in_valid = 1'b0;

    // Streaming with out_ready high: one-cycle latency, full throughput.
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      push(W'(k));
      chk("stream_data",  out_data, W'(k));
      chk("stream_ready", W'(in_ready), W'(1'b1));
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_empty", W'(out_valid), W'(1'b0));

    // Backpressure fills the skid slot.
    out_ready = 1'b0;
    push(W'(8'h11));
    push(W'(8'h22));
    chk("skid_occ",   W'(occupancy), W'(2));
    chk("skid_ready", W'(in_ready), W'(1'b0));
    chk("skid_head",  out_data, W'(8'h11));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("skid_second", out_data, W'(8'h22));
    cycle();
    chk("skid_done_valid", W'(out_valid), W'(1'b0));
    chk("skid_done_data",  out_data, W'(0));

    // Flush with a full buffer and a simultaneous offer.
    out_ready = 1'b0;
    push(W'(8'h77));
    push(W'(8'h78));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = W'(8'h33);
    cycle();
    chk("flush_occ",   W'(occupancy), W'(0));
    chk("flush_valid", W'(out_valid), W'(1'b0));
    chk("flush_data",  out_data, W'(0));
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("flush_no_33", W'(out_valid), W'(1'b0));

    // Accept and drain together in ONE.
    out_ready = 1'b0;
    push(W'(8'h44));
    out_ready = 1'b1;
    push(W'(8'h55));
    chk("ad_data", out_data, W'(8'h55));
    chk("ad_occ",  W'(occupancy), W'(1));
    in_valid = 1'b0;
    cycle();

    // Reset pulse while stalled and full.
    out_ready = 1'b0;
    push(W'(8'h01));
    push(W'(8'h02));
    in_valid = 1'b0;
    reset    = 1'b1;
    cycle();
    chk("rst2_occ",   W'(occupancy), W'(0));
    chk("rst2_valid", W'(out_valid), W'(1'b0));
    chk("rst2_ready", W'(in_ready), W'(1'b1));
    reset = 1'b0;
    push(W'(8'h66));
    chk("rst2_push", out_data, W'(8'h66));
    in_valid = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 149) == 0);
      in_data   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
